snes_pad_coleco_ctrl: RTL and testbench

Controller front-end that sits upstream of porta_glue_coleco's controller inputs. It polls an SNES-style serial gamepad (latch/clock/data), registers the button state once per poll frame, and drives the ColecoVision controller matrix lines C_0..C_3, C_5 and C_6. Which matrix it drives is selected by the glue's arm (C_4) and fire (C_7) common strobes. One instance is used per player.

---
 rtl/snes_pad_coleco_ctrl.sv | 153 +++++++++++++++
 tb/tb_snes_pad_coleco_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_coleco_ctrl.sv
// Polls an SNES serial pad once per poll period and drives one player's ColecoVision matrix lines.
// Latency: buttons/frame_stb update once per LATCH_CYC+32*HALF_CYC+1 frame; matrix lines are combinational.
module snes_pad_coleco_ctrl #(
    parameter int LATCH_CYC = 43,
    parameter int HALF_CYC  = 21,
    parameter int POLL_CYC  = 59659
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic        arm_n,
    input  logic        fire_n,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic        C_0,
    output logic        C_1,
    output logic        C_2,
    output logic        C_3,
    output logic        C_5,
    output logic        C_6,
    output logic [11:0] buttons,
    output logic        frame_stb
);

    localparam int PW     = $clog2(POLL_CYC);
    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PHW    = $clog2(PH_MAX);

    localparam logic [PW-1:0]  POLL_RELOAD = PW'(POLL_CYC - 1);
    localparam logic [PHW-1:0] LATCH_LAST  = PHW'(LATCH_CYC - 1);
    localparam logic [PHW-1:0] HALF_LAST   = PHW'(HALF_CYC - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, COMMIT} state_t;

    state_t          state;
    logic [PW-1:0]   poll_cnt;
    logic [PHW-1:0]  phase;
    logic [3:0]      bit_idx;
    logic [11:0]     shift_q;
    logic [1:0]      data_sync;

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state     <= IDLE;
            poll_cnt  <= '0;
            phase     <= '0;
            bit_idx   <= '0;
            shift_q   <= '1;
            data_sync <= 2'b11;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            buttons   <= '0;
            frame_stb <= 1'b0;
        end else begin
            data_sync <= {data_sync[0], pad_data};
            frame_stb <= 1'b0;
            // Poll period is measured latch-rise to latch-rise, so the counter runs through the frame.
            if (poll_cnt != '0)
                poll_cnt <= poll_cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (poll_cnt == '0) begin
                        state     <= LATCH;
                        poll_cnt  <= POLL_RELOAD;
                        phase     <= '0;
                        pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        state     <= LOW;
                        phase     <= '0;
                        bit_idx   <= '0;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LOW: begin
                    if (phase == HALF_LAST) begin
                        // Bits 12-15 are still clocked out of the pad but not kept.
                        if (bit_idx < 4'd12)
                            shift_q[bit_idx] <= data_sync[1];
                        state   <= HIGH;
                        phase   <= '0;
                        pad_clk <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == HALF_LAST) begin
                        phase <= '0;
                        if (bit_idx == 4'd15) begin
                            state <= COMMIT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= LOW;
                            pad_clk <= 1'b0;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                COMMIT: begin
                    buttons   <= ~shift_q;
                    frame_stb <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [3:0] joy_lines;
    logic [3:0] key_code;
    logic [3:0] lines;
    logic       btn_line;

    always_comb begin
        joy_lines = {~buttons[6], ~buttons[5], ~buttons[7], ~buttons[4]};

        key_code = 4'hF;
        if (buttons[3])       key_code = 4'hD;
        else if (buttons[2])  key_code = 4'h7;
        else if (buttons[9])  key_code = 4'hC;
        else if (buttons[1])  key_code = 4'h2;
        else if (buttons[10]) key_code = 4'h6;
        else if (buttons[11]) key_code = 4'h9;

        // Both strobes low behaves like the real open-collector wired-AND of both matrices.
        lines    = 4'hF;
        btn_line = 1'b1;
        if (!fire_n) begin
            lines    = lines & joy_lines;
            btn_line = btn_line & ~buttons[0];
        end
        if (!arm_n) begin
            lines    = lines & key_code;
            btn_line = btn_line & ~buttons[8];
        end
    end

    assign C_0 = lines[0];
    assign C_1 = lines[1];
    assign C_2 = lines[2];
    assign C_3 = lines[3];
    assign C_5 = 1'b1;
    assign C_6 = btn_line;

endmodule

// File: tb/tb_snes_pad_coleco_ctrl.sv
// Bench for snes_pad_coleco_ctrl: pad model, frame timing, matrix decode against a reference table.
module tb_snes_pad_coleco_ctrl;

    localparam int LC = 4;
    localparam int HC = 3;
    localparam int PC = 200;

    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic        arm_n = 1'b1;
    logic        fire_n = 1'b1;
    logic        pad_data;
    logic        pad_latch, pad_clk;
    logic        C_0, C_1, C_2, C_3, C_5, C_6;
    logic [11:0] buttons;
    logic        frame_stb;

    logic [15:0] pad_word = 16'hFFFF;
    logic [15:0] pad_sh = 16'hFFFF;
    logic        disc = 1'b0;

    int errors = 0;
    int checks = 0;

    snes_pad_coleco_ctrl #(.LATCH_CYC(LC), .HALF_CYC(HC), .POLL_CYC(PC)) dut (
        .clk(clk), .RESETn(RESETn), .arm_n(arm_n), .fire_n(fire_n),
        .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .C_0(C_0), .C_1(C_1), .C_2(C_2), .C_3(C_3), .C_5(C_5), .C_6(C_6),
        .buttons(buttons), .frame_stb(frame_stb)
    );

    always #5 clk = ~clk;

    // Pad: parallel load while latched, shift on clock rise, 1s shift in behind the word.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_sh <= pad_word;
        else           pad_sh <= {1'b1, pad_sh[15:1]};
    end
    assign pad_data = disc | pad_sh[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {C_6,C_3,C_2,C_1,C_0} from pressed-button mask and strobes.
    function automatic logic [4:0] ref_lines(input logic [11:0] p, input logic a_n, input logic f_n);
        int         keys [6];
        logic [3:0] codes [6];
        logic [4:0] j, k, r;
        logic       found;
        keys  = '{3, 2, 9, 1, 10, 11};
        codes = '{4'hD, 4'h7, 4'hC, 4'h2, 4'h6, 4'h9};
        j = {~p[0], ~p[6], ~p[5], ~p[7], ~p[4]};
        k = {~p[8], 4'hF};
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found && p[keys[i]]) begin
                k[3:0] = codes[i];
                found  = 1'b1;
            end
        end
        r = 5'h1F;
        if (!f_n) r = r & j;
        if (!a_n) r = r & k;
        return r;
    endfunction

    function automatic logic [4:0] dut_lines();
        return {C_6, C_3, C_2, C_1, C_0};
    endfunction

    task automatic check_lines(input string tag, input logic [11:0] p);
        for (int s = 0; s < 4; s++) begin
            arm_n  = s[0];
            fire_n = s[1];
            #1;
            check($sformatf("%s a%0d f%0d", tag, s[0], s[1]),
                  32'({C_5, dut_lines()}), 32'({1'b1, ref_lines(p, s[0], s[1])}));
        end
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (n < PC + 50) begin
            @(negedge clk);
            if (frame_stb) break;
            n++;
        end
        check({tag, " stb"}, 32'(frame_stb), 32'd1);
    endtask

    task automatic wait_latch(input string tag);
        int n = 0;
        while (n < PC + 50) begin
            @(negedge clk);
            if (pad_latch) break;
            n++;
        end
        check({tag, " latch"}, 32'(pad_latch), 32'd1);
    endtask

    // Call only right after a frame_stb so the next frame latches the new word.
    task automatic frame(input string tag, input logic [11:0] p, input logic [3:0] hi);
        pad_word = ~{hi, p};
        wait_stb(tag);
        check({tag, " buttons"}, 32'(buttons), 32'(p));
    endtask

    initial begin
        logic [11:0] p;
        logic        exp_clk;
        logic        stb_seen;
        int          k;

        repeat (3) @(negedge clk);
        check("rst latch", 32'(pad_latch), 32'd0);
        check("rst pclk", 32'(pad_clk), 32'd1);
        check("rst buttons", 32'(buttons), 32'd0);
        check("rst stb", 32'(frame_stb), 32'd0);
        check("rst lines", 32'({C_5, dut_lines()}), 32'h3F);

        pad_word = 16'hFFEE;
        RESETn = 1'b1;
        for (int c = 0; c < 204; c++) begin
            @(negedge clk);
            exp_clk = 1'b1;
            if (c >= LC && c < LC + 32 * HC)
                exp_clk = (((c - LC) / HC) % 2) == 1;
            check($sformatf("wave latch c%0d", c), 32'(pad_latch), 32'((c < LC) || (c >= PC)));
            check($sformatf("wave pclk c%0d", c), 32'(pad_clk), 32'(exp_clk));
            check($sformatf("wave stb c%0d", c), 32'(frame_stb), 32'(c == LC + 32 * HC + 1));
            if (c == LC + 32 * HC + 1)
                check("first buttons", 32'(buttons), 32'h011);
        end

        fire_n = 1'b0; arm_n = 1'b1; #1;
        check("joy C_0", 32'(C_0), 32'd0);
        check("joy C_6", 32'(C_6), 32'd0);
        check("joy C_3..1", 32'({C_3, C_2, C_1}), 32'b111);
        check("joy C_5", 32'(C_5), 32'd1);
        check_lines("upb", 12'h011);

        wait_stb("sync");
        frame("start+L", 12'h408, 4'h0);
        arm_n = 1'b0; fire_n = 1'b1; #1;
        check("key prio", 32'({C_3, C_2, C_1, C_0}), 32'hD);
        frame("L", 12'h400, 4'h0);
        arm_n = 1'b0; fire_n = 1'b1; #1;
        check("key L", 32'({C_3, C_2, C_1, C_0}), 32'h6);
        frame("L+A", 12'h500, 4'h0);
        arm_n = 1'b0; fire_n = 1'b1; #1;
        check("key A", 32'(C_6), 32'd0);
        check_lines("L+A", 12'h500);

        frame("right+X", 12'h280, 4'hF);
        arm_n = 1'b0; fire_n = 1'b0; #1;
        check("both low", 32'({C_6, C_3, C_2, C_1, C_0}), 32'h1C);
        arm_n = 1'b1; fire_n = 1'b1; #1;
        check("both high", 32'({C_6, C_3, C_2, C_1, C_0}), 32'h1F);

        pad_word = ~{4'h0, 12'h0F0};
        wait_latch("hold");
        repeat (60) @(negedge clk);
        check("hold midframe", 32'(buttons), 32'h280);
        wait_stb("hold");
        check("hold commit", 32'(buttons), 32'h0F0);

        for (int r = 0; r < 8; r++) begin
            p = 12'($urandom);
            frame($sformatf("rnd%0d", r), p, 4'($urandom));
            check_lines($sformatf("rnd%0d", r), p);
        end

        frame("none", 12'h000, 4'h0);
        pad_word = ~{4'h0, 12'h5A5};
        wait_latch("abort");
        repeat (LC + 7 * 2 * HC) @(negedge clk);
        RESETn = 1'b0;
        stb_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            stb_seen = stb_seen | frame_stb;
        end
        check("abort stb", 32'(stb_seen), 32'd0);
        check("abort buttons", 32'(buttons), 32'd0);
        check("abort latch", 32'(pad_latch), 32'd0);
        check("abort pclk", 32'(pad_clk), 32'd1);
        RESETn = 1'b1;
        @(posedge clk);
        #1;
        check("fresh latch", 32'(pad_latch), 32'd1);
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (frame_stb) break;
            k++;
        end
        check("fresh frame len", 32'(k), 32'(LC + 32 * HC + 1));
        check("fresh buttons", 32'(buttons), 32'h5A5);

        disc = 1'b1;
        pad_word = 16'h0000;
        for (int r = 0; r < 2; r++) begin
            wait_stb($sformatf("disc%0d", r));
            check($sformatf("disc%0d buttons", r), 32'(buttons), 32'd0);
            arm_n = 1'b0; fire_n = 1'b1; #1;
            check($sformatf("disc%0d key", r), 32'({C_6, C_3, C_2, C_1, C_0}), 32'h1F);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
